// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, state codes and
// datapath select codes, plus the bundled control-word type driven by the FSM.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StIf    = 4'd1,
    StId    = 4'd2,
    StMaddr = 4'd3,
    StMrd   = 4'd4,
    StMwb   = 4'd5,
    StMwr   = 4'd6,
    StRexe  = 4'd7,
    StRwb   = 4'd8,
    StBeq   = 4'd9,
    StJmp   = 4'd10,
    StAexe  = 4'd11,
    StAwb   = 4'd12,
    StErr   = 4'd13
  } state_e;

  localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Control FSM of the multicycle MIPS datapath. Moore outputs per state, except the
// IF-stage IR/PC write strobes which are gated by the memory handshake.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_illegal,
  output logic [3:0] o_state_dbg
);

  state_e r_state;
  state_e w_state_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = StIdle;
    unique case (r_state)
      StIdle:  w_state_next = StIf;
      StIf:    w_state_next = i_mem_ready ? StId : StIf;
      StId: begin
        if (is_mem_op(i_opcode))        w_state_next = StMaddr;
        else if (i_opcode == OP_RTYPE)  w_state_next = StRexe;
        else if (i_opcode == OP_BEQ)    w_state_next = StBeq;
        else if (i_opcode == OP_J)      w_state_next = StJmp;
        else if (i_opcode == OP_ADDI)   w_state_next = StAexe;
        else                            w_state_next = StErr;
      end
      StMaddr: w_state_next = (i_opcode == OP_LW) ? StMrd : StMwr;
      StMrd:   w_state_next = i_mem_ready ? StMwb : StMrd;
      StMwb:   w_state_next = StIf;
      StMwr:   w_state_next = i_mem_ready ? StIf : StMwr;
      StRexe:  w_state_next = StRwb;
      StRwb:   w_state_next = StIf;
      StBeq:   w_state_next = StIf;
      StJmp:   w_state_next = StIf;
      StAexe:  w_state_next = StAwb;
      StAwb:   w_state_next = StIf;
      StErr:   w_state_next = StErr;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_NONE;
    unique case (r_state)
      StIf: begin
        // IR and PC load only on the cycle memory delivers, i.e. the exit edge.
        w_ctrl.ir_write  = i_mem_ready;
        w_ctrl.pc_write  = i_mem_ready;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.i_or_d    = 1'b0;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = ALU_SRC_B_FOUR;
        w_ctrl.alu_op    = ALU_OP_ADD;
        w_ctrl.pc_source = PC_SRC_ALU;
      end
      StId: begin
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = ALU_SRC_B_IMM_SH;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      StMaddr: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALU_SRC_B_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      StMrd: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      StMwb: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
      end
      StMwr: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      StRexe: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALU_SRC_B_REG;
        w_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      StRwb: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
      end
      StBeq: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = ALU_SRC_B_REG;
        w_ctrl.alu_op        = ALU_OP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      StJmp: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PC_SRC_JUMP;
      end
      StAexe: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALU_SRC_B_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      StAwb: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
      end
      StErr:   w_ctrl.illegal = 1'b1;
      default: w_ctrl = CTRL_NONE;
    endcase
  end

  assign o_ir_write      = w_ctrl.ir_write;
  assign o_pc_write      = w_ctrl.pc_write;
  assign o_pc_write_cond = w_ctrl.pc_write_cond;
  assign o_i_or_d        = w_ctrl.i_or_d;
  assign o_mem_read      = w_ctrl.mem_read;
  assign o_mem_write     = w_ctrl.mem_write;
  assign o_mem_to_reg    = w_ctrl.mem_to_reg;
  assign o_reg_dst       = w_ctrl.reg_dst;
  assign o_reg_write     = w_ctrl.reg_write;
  assign o_alu_src_a     = w_ctrl.alu_src_a;
  assign o_alu_src_b     = w_ctrl.alu_src_b;
  assign o_alu_op        = w_ctrl.alu_op;
  assign o_pc_source     = w_ctrl.pc_source;
  assign o_illegal       = w_ctrl.illegal;
  assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle and
// compares state and the full control word against hand-written per-state values.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl u_dut (
    .clk             (clk),
    .rst             (rst),
    .i_opcode        (opcode),
    .i_mem_ready     (mem_ready),
    .o_ir_write      (ir_write),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_i_or_d        (i_or_d),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_dst       (reg_dst),
    .o_reg_write     (reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_pc_source     (pc_source),
    .o_illegal       (illegal),
    .o_state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: ir,pcw,pwc,iord,mrd,mwr,m2r,rdst,rw,asa,asb[2],aluop[2],pcsrc[2],illegal
  logic [16:0] w_outs;
  assign w_outs = {ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

  localparam logic [16:0] E_ZERO    = '0;
  localparam logic [16:0] E_IF_WAIT = {10'b0000100000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_IF_GO   = {10'b1100100000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_ID      = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MADDR   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MRD     = {10'b0001100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MWB     = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MWR     = {10'b0001010000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_REXE    = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] E_RWB     = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_BEQ     = {10'b0010000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [16:0] E_JMP     = {10'b0100000000, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] E_AEXE    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_AWB     = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_ERR     = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check the current cycle (after inputs settle), then advance one clock.
  task automatic cyc(input string tag, input state_e st, input logic [16:0] exp);
    #1;
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
    check({tag, ".outs"}, 32'(w_outs), 32'(exp));
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = OP_RTYPE;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    cyc("rst_hold", StIdle, E_ZERO);
    rst = 1'b0;
    cyc("idle_after_rst", StIdle, E_ZERO);
    cyc("if_wait0", StIf, E_IF_WAIT);
    cyc("if_wait1", StIf, E_IF_WAIT);
    mem_ready = 1'b1;
    cyc("if_go", StIf, E_IF_GO);
    cyc("r_id", StId, E_ID);
    // Reset mid-REXE must drop everything at once.
    #1;
    check("rexe_before_rst", 32'(state_dbg), 32'(StRexe));
    rst = 1'b1;
    cyc("rst_mid_rexe", StIdle, E_ZERO);
    cyc("rst_mid_rexe_hold", StIdle, E_ZERO);
    rst = 1'b0;
    cyc("idle_post_rst", StIdle, E_ZERO);

    // R-type
    cyc("r_if", StIf, E_IF_GO);
    cyc("r_id2", StId, E_ID);
    cyc("r_exe", StRexe, E_REXE);
    cyc("r_wb", StRwb, E_RWB);

    // lw with memory stalling three cycles in MRD
    opcode = OP_LW;
    cyc("lw_if", StIf, E_IF_GO);
    mem_ready = 1'b0;
    cyc("lw_id", StId, E_ID);
    cyc("lw_maddr", StMaddr, E_MADDR);
    for (int i = 0; i < 3; i++) cyc("lw_mrd_wait", StMrd, E_MRD);
    mem_ready = 1'b1;
    cyc("lw_mrd_go", StMrd, E_MRD);
    cyc("lw_mwb", StMwb, E_MWB);

    // sw
    opcode = OP_SW;
    cyc("sw_if", StIf, E_IF_GO);
    cyc("sw_id", StId, E_ID);
    cyc("sw_maddr", StMaddr, E_MADDR);
    cyc("sw_mwr", StMwr, E_MWR);

    // beq
    opcode = OP_BEQ;
    cyc("beq_if", StIf, E_IF_GO);
    cyc("beq_id", StId, E_ID);
    cyc("beq_ex", StBeq, E_BEQ);

    // j
    opcode = OP_J;
    cyc("j_if", StIf, E_IF_GO);
    cyc("j_id", StId, E_ID);
    cyc("j_ex", StJmp, E_JMP);

    // addi
    opcode = OP_ADDI;
    cyc("addi_if", StIf, E_IF_GO);
    cyc("addi_id", StId, E_ID);
    cyc("addi_ex", StAexe, E_AEXE);
    cyc("addi_wb", StAwb, E_AWB);

    // Unsupported opcode: sticky error regardless of mem_ready
    opcode = 6'b111111;
    cyc("bad_if", StIf, E_IF_GO);
    cyc("bad_id", StId, E_ID);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      cyc("err_sticky", StErr, E_ERR);
    end
    rst = 1'b1;
    cyc("err_cleared", StIdle, E_ZERO);
    rst = 1'b0;
    mem_ready = 1'b1;
    opcode = OP_RTYPE;
    cyc("err_idle", StIdle, E_ZERO);
    cyc("err_if", StIf, E_IF_GO);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
